// File: rtl/obuf_pkg.sv
// ============================================================================
// Module  : obuf_pkg
// Brief   : Shared types, default sizes and overflow helper for the output
//           accumulation buffer.
// Revision: 1.0
// ============================================================================
`default_nettype none

package obuf_pkg;

    localparam int c_default_data_w = 32;
    localparam int c_default_depth  = 16;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        DRAIN = 1'b1
    } obuf_state_e;

    // Signed overflow of a + b, judged at bit (width-1); width must be 1..64.
    function automatic logic add_ovf(
        input logic [63:0] a,
        input logic [63:0] b,
        input int unsigned width
    );
        logic [63:0] sum;
        logic [5:0]  msb;
        sum = a + b;
        msb = 6'(width - 1);
        return (a[msb] == b[msb]) && (sum[msb] != a[msb]);
    endfunction

endpackage

`default_nettype wire

// File: rtl/obuf_drain_ctrl.sv
// ============================================================================
// Module  : obuf_drain_ctrl
// Brief   : Drain sequencer: walks ptr/remaining, issues one read per free
//           output slot and holds the beat under backpressure.
// Revision: 1.0
// ============================================================================
`default_nettype none

module obuf_drain_ctrl
    import obuf_pkg::*;
#(
    parameter int DATA_W = c_default_data_w,
    parameter int DEPTH  = c_default_depth,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              drain_start,
    input  logic [ADDR_W-1:0] drain_base,
    input  logic [ADDR_W:0]   drain_len,
    input  logic [DATA_W-1:0] rd_data,
    input  logic              out_ready,
    output logic              rd_en,
    output logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    output logic              out_last,
    output logic              busy
);

    localparam logic [ADDR_W:0] c_len_max = (ADDR_W + 1)'(DEPTH);
    localparam logic [ADDR_W:0] c_len_one = (ADDR_W + 1)'(1);

    obuf_state_e       state_q, state_d;
    logic [ADDR_W-1:0] ptr_q, ptr_d;
    logic [ADDR_W:0]   remaining_q, remaining_d;
    logic [DATA_W-1:0] out_data_q, out_data_d;
    logic              out_valid_q, out_valid_d;
    logic              out_last_q, out_last_d;
    logic              w_start_ok;
    logic              w_issue;

    // A pending final beat still counts as busy, so a new drain cannot start under it.
    assign busy       = (state_q != IDLE) || out_valid_q;
    assign w_start_ok = (state_q == IDLE) && !out_valid_q && drain_start &&
                        (drain_len != '0) && (drain_len <= c_len_max);
    assign w_issue    = (state_q == DRAIN) && (!out_valid_q || out_ready);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            ptr_q       <= '0;
            remaining_q <= '0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            remaining_q <= remaining_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            out_last_q  <= out_last_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (w_start_ok) state_d = DRAIN;
            DRAIN:   if (w_issue && (remaining_q == c_len_one)) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        ptr_d       = ptr_q;
        remaining_d = remaining_q;
        out_data_d  = out_data_q;
        out_valid_d = out_valid_q;
        out_last_d  = out_last_q;
        if (w_start_ok) begin
            ptr_d       = drain_base;
            remaining_d = drain_len;
        end
        if (w_issue) begin
            out_data_d  = rd_data;
            out_valid_d = 1'b1;
            out_last_d  = (remaining_q == c_len_one);
            ptr_d       = ptr_q + 1'b1;
            remaining_d = remaining_q - c_len_one;
        end else if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
            out_last_d  = 1'b0;
        end
    end

    assign rd_en     = w_issue;
    assign rd_addr   = ptr_q;
    assign out_data  = out_data_q;
    assign out_valid = out_valid_q;
    assign out_last  = out_last_q;

endmodule

`default_nettype wire

// File: rtl/output_accum_buffer.sv
// ============================================================================
// Module  : output_accum_buffer
// Brief   : Overwrite/accumulate entry buffer with valid bits, sticky signed
//           overflow and a valid/ready multi-beat drain.
//           Optional: OBUF_CLEAR_ON_DRAIN_EN makes drain reads destructive.
// Revision: 1.0
// ============================================================================
`default_nettype none

module output_accum_buffer
    import obuf_pkg::*;
#(
    parameter int DATA_W = c_default_data_w,
    parameter int DEPTH  = c_default_depth,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en,
    input  logic              wr_acc,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              drain_start,
    input  logic [ADDR_W-1:0] drain_base,
    input  logic [ADDR_W:0]   drain_len,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              out_last,
    output logic              busy,
    output logic [DEPTH-1:0]  entry_valid,
    output logic              acc_ovf
);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] mem_d [DEPTH];
    logic [DEPTH-1:0]  entry_valid_q, entry_valid_d;
    logic              acc_ovf_q, acc_ovf_d;

    logic [DATA_W-1:0] w_acc_old;
    logic [DATA_W-1:0] w_acc_sum;
    logic [DATA_W-1:0] w_wr_value;
    logic [DATA_W-1:0] w_rd_data;
    logic              w_rd_en;
    logic [ADDR_W-1:0] w_rd_addr;

    // Reads see pre-write contents, which gives read-before-write on a collision.
    always_comb begin
        w_acc_old  = entry_valid_q[wr_addr] ? mem_q[wr_addr] : '0;
        w_acc_sum  = w_acc_old + wr_data;
        w_wr_value = wr_acc ? w_acc_sum : wr_data;
        acc_ovf_d  = acc_ovf_q |
                     (wr_en & wr_acc & add_ovf(64'(w_acc_old), 64'(wr_data), DATA_W));
        w_rd_data  = (w_rd_en && entry_valid_q[w_rd_addr]) ? mem_q[w_rd_addr] : '0;
    end

    always_comb begin
        mem_d         = mem_q;
        entry_valid_d = entry_valid_q;
`ifdef OBUF_CLEAR_ON_DRAIN_EN
        if (w_rd_en) begin
            mem_d[w_rd_addr]         = '0;
            entry_valid_d[w_rd_addr] = 1'b0;
        end
`endif
        // Applied last so a same-cycle write outranks a drain clear.
        if (wr_en) begin
            mem_d[wr_addr]         = w_wr_value;
            entry_valid_d[wr_addr] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            entry_valid_q <= '0;
            acc_ovf_q     <= 1'b0;
        end else begin
            mem_q         <= mem_d;
            entry_valid_q <= entry_valid_d;
            acc_ovf_q     <= acc_ovf_d;
        end
    end

    obuf_drain_ctrl #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_drain_ctrl (
        .clk         (clk),
        .rst         (rst),
        .drain_start (drain_start),
        .drain_base  (drain_base),
        .drain_len   (drain_len),
        .rd_data     (w_rd_data),
        .out_ready   (out_ready),
        .rd_en       (w_rd_en),
        .rd_addr     (w_rd_addr),
        .out_data    (out_data),
        .out_valid   (out_valid),
        .out_last    (out_last),
        .busy        (busy)
    );

    assign entry_valid = entry_valid_q;
    assign acc_ovf     = acc_ovf_q;

endmodule

`default_nettype wire
